// File: rtl/pid_filter_pkg.sv
// Shared definitions for the multi-channel PID filter.
//   state_t     : sequencer states (one sample in flight at a time)
//   sat_dir_t   : result of the output range check
//   *_DEF       : default generic widths and the derived error/product/sum widths
//   chan_width  : channel tag width for a given channel count (never below 1)
//   saturate    : classifies a wide signed value against a W-bit signed range
package pid_filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_INTEG,
        ST_MULT,
        ST_SUM
    } state_t;

    typedef enum logic [1:0] {
        SAT_NONE,
        SAT_HI,
        SAT_LO
    } sat_dir_t;

    function automatic int chan_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int W_DATA_DEF = 18;
    localparam int W_COEF_DEF = 16;
    localparam int W_INT_DEF  = 32;
    localparam int W_OUT_DEF  = 18;
    localparam int N_CHAN_DEF = 8;
    localparam int W_CHAN_DEF = chan_width(N_CHAN_DEF);

    // Error carries one extra bit, derivative two, so neither can wrap.
    localparam int W_ERR_DEF   = W_DATA_DEF + 1;
    localparam int W_DER_DEF   = W_DATA_DEF + 2;
    localparam int W_PROD_P_DEF = W_COEF_DEF + W_ERR_DEF;
    localparam int W_PROD_I_DEF = W_COEF_DEF + W_INT_DEF;
    localparam int W_PROD_D_DEF = W_COEF_DEF + W_DER_DEF;
    localparam int W_SUM_DEF    = W_COEF_DEF + W_INT_DEF + 2;

    // The caller builds the clipped word itself, so only the direction is
    // returned; this keeps the full-width sum out of the output path.
    function automatic sat_dir_t saturate(input logic signed [63:0] v, input int w_out);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w_out - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return SAT_HI;
        if (v < lo) return SAT_LO;
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/pid_filter_mc_if.sv
// Sample-in / control-word-out stream bundle of the PID filter.
//   din_in, din_chan_in, din_dv_in, din_ready_out : channel-tagged sample handshake
//   dout_out, dout_chan_out, dout_dv_out, sat_out  : channel-tagged output word
// slave = filter side, master = upstream/downstream side.
interface pid_filter_mc_if #(
    parameter int W_DATA = pid_filter_pkg::W_DATA_DEF,
    parameter int W_OUT  = pid_filter_pkg::W_OUT_DEF,
    parameter int W_CHAN = pid_filter_pkg::W_CHAN_DEF
);
    logic signed [W_DATA-1:0] din_in;
    logic [W_CHAN-1:0]        din_chan_in;
    logic                     din_dv_in;
    logic                     din_ready_out;
    logic signed [W_OUT-1:0]  dout_out;
    logic [W_CHAN-1:0]        dout_chan_out;
    logic                     dout_dv_out;
    logic                     sat_out;

    modport master (
        output din_in, din_chan_in, din_dv_in,
        input  din_ready_out, dout_out, dout_chan_out, dout_dv_out, sat_out
    );

    modport slave (
        input  din_in, din_chan_in, din_dv_in,
        output din_ready_out, dout_out, dout_chan_out, dout_dv_out, sat_out
    );
endinterface

// File: rtl/pid_chan_store.sv
// Per-channel configuration and filter state register file.
//   cfg_*      : write port for setpoint, P/I/D coefficients and integral limit
//   commit_*   : write port for integral and previous error of one channel
//   lock_en_in : a low bit holds that channel's integral and e_prev at zero
//   rd_*       : combinational read of the channel selected by rd_chan_in
module pid_chan_store
    import pid_filter_pkg::*;
#(
    parameter int N_CHAN = N_CHAN_DEF,
    parameter int W_CHAN = chan_width(N_CHAN),
    parameter int W_DATA = W_DATA_DEF,
    parameter int W_COEF = W_COEF_DEF,
    parameter int W_INT  = W_INT_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     cfg_wr_in,
    input  logic [W_CHAN-1:0]        cfg_chan_in,
    input  logic signed [W_COEF-1:0] cfg_setpoint_in,
    input  logic signed [W_COEF-1:0] cfg_p_in,
    input  logic signed [W_COEF-1:0] cfg_i_in,
    input  logic signed [W_COEF-1:0] cfg_d_in,
    input  logic [W_INT-2:0]         cfg_int_lim_in,
    input  logic                     commit_en_in,
    input  logic [W_CHAN-1:0]        commit_chan_in,
    input  logic signed [W_INT-1:0]  commit_int_in,
    input  logic signed [W_DATA:0]   commit_eprev_in,
    input  logic [N_CHAN-1:0]        lock_en_in,
    input  logic [W_CHAN-1:0]        rd_chan_in,
    output logic signed [W_COEF-1:0] rd_setpoint_out,
    output logic signed [W_COEF-1:0] rd_p_out,
    output logic signed [W_COEF-1:0] rd_i_out,
    output logic signed [W_COEF-1:0] rd_d_out,
    output logic [W_INT-2:0]         rd_int_lim_out,
    output logic signed [W_INT-1:0]  rd_int_out,
    output logic signed [W_DATA:0]   rd_eprev_out
);
    logic signed [W_COEF-1:0] sp_mem    [N_CHAN];
    logic signed [W_COEF-1:0] p_mem     [N_CHAN];
    logic signed [W_COEF-1:0] i_mem     [N_CHAN];
    logic signed [W_COEF-1:0] d_mem     [N_CHAN];
    logic [W_INT-2:0]         lim_mem   [N_CHAN];
    logic signed [W_INT-1:0]  int_mem   [N_CHAN];
    logic signed [W_DATA:0]   eprev_mem [N_CHAN];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int c = 0; c < N_CHAN; c++) begin
                sp_mem[c]    <= '0;
                p_mem[c]     <= '0;
                i_mem[c]     <= '0;
                d_mem[c]     <= '0;
                lim_mem[c]   <= '1;
                int_mem[c]   <= '0;
                eprev_mem[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                // Out-of-range cfg_chan_in matches no channel and is dropped.
                if (cfg_wr_in && (int'(cfg_chan_in) == c)) begin
                    sp_mem[c]  <= cfg_setpoint_in;
                    p_mem[c]   <= cfg_p_in;
                    i_mem[c]   <= cfg_i_in;
                    d_mem[c]   <= cfg_d_in;
                    lim_mem[c] <= cfg_int_lim_in;
                end
                // Unlocked channels are held clear, even against a commit.
                if (!lock_en_in[c]) begin
                    int_mem[c]   <= '0;
                    eprev_mem[c] <= '0;
                end else if (commit_en_in && (int'(commit_chan_in) == c)) begin
                    int_mem[c]   <= commit_int_in;
                    eprev_mem[c] <= commit_eprev_in;
                end
            end
        end
    end

    assign rd_setpoint_out = sp_mem[rd_chan_in];
    assign rd_p_out        = p_mem[rd_chan_in];
    assign rd_i_out        = i_mem[rd_chan_in];
    assign rd_d_out        = d_mem[rd_chan_in];
    assign rd_int_lim_out  = lim_mem[rd_chan_in];
    assign rd_int_out      = int_mem[rd_chan_in];
    assign rd_eprev_out    = eprev_mem[rd_chan_in];

endmodule

// File: rtl/pid_filter_mc.sv
// Time-multiplexed multi-channel PID filter, one sample every 5 cycles.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   bus (slave)    : channel-tagged sample in, channel-tagged saturated word out
//   lock_en_in     : per-channel enable; disabled channels drop samples and
//                    have their integral/previous error held at zero
//   cfg_*          : per-channel setpoint, P/I/D and integral limit writes
module pid_filter_mc
    import pid_filter_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF,
    parameter int W_COEF = W_COEF_DEF,
    parameter int W_INT  = W_INT_DEF,
    parameter int W_OUT  = W_OUT_DEF,
    parameter int N_CHAN = N_CHAN_DEF,
    localparam int W_CHAN = chan_width(N_CHAN)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    pid_filter_mc_if.slave           bus,
    input  logic [N_CHAN-1:0]        lock_en_in,
    input  logic [W_CHAN-1:0]        cfg_chan_in,
    input  logic signed [W_COEF-1:0] cfg_setpoint_in,
    input  logic signed [W_COEF-1:0] cfg_p_in,
    input  logic signed [W_COEF-1:0] cfg_i_in,
    input  logic signed [W_COEF-1:0] cfg_d_in,
    input  logic [W_INT-2:0]         cfg_int_lim_in,
    input  logic                     cfg_wr_in
);
    localparam int W_E  = W_DATA + 1;
    localparam int W_D  = W_DATA + 2;
    localparam int W_IA = W_INT + 1;
    localparam int W_PP = W_COEF + W_E;
    localparam int W_PI = W_COEF + W_INT;
    localparam int W_PD = W_COEF + W_D;
    localparam int W_S  = W_COEF + W_INT + 2;

    state_t                   state_reg;
    logic signed [W_DATA-1:0] x_reg;
    logic [W_CHAN-1:0]        chan_reg;
    logic signed [W_COEF-1:0] sp_reg, kp_reg, ki_reg, kd_reg;
    logic [W_INT-2:0]         lim_reg;
    logic signed [W_E-1:0]    e_reg;
    logic signed [W_INT-1:0]  int_reg;
    logic signed [W_D-1:0]    der_reg;
    logic signed [W_PP-1:0]   prod_p_reg;
    logic signed [W_PI-1:0]   prod_i_reg;
    logic signed [W_PD-1:0]   prod_d_reg;
    logic signed [W_OUT-1:0]  dout_reg;
    logic [W_CHAN-1:0]        dout_chan_reg;
    logic                     dout_dv_reg;
    logic                     sat_reg;

    logic [W_CHAN-1:0]        rd_chan;
    logic signed [W_COEF-1:0] rd_sp, rd_p, rd_i, rd_d;
    logic [W_INT-2:0]         rd_lim;
    logic signed [W_INT-1:0]  rd_int;
    logic signed [W_E-1:0]    rd_eprev;

    logic                     chan_ok;
    logic signed [W_IA-1:0]   int_sum, lim_pos, lim_neg;
    logic signed [W_INT-1:0]  int_new;
    logic signed [W_D-1:0]    der_new;
    logic signed [W_S-1:0]    sum_all;
    sat_dir_t                 sat_dir;
    logic signed [W_OUT-1:0]  sat_word;

    // While idle the store is addressed by the incoming tag so the config can
    // be snapshotted on the transfer edge; afterwards by the in-flight channel.
    assign rd_chan = (state_reg == ST_IDLE) ? bus.din_chan_in : chan_reg;
    assign chan_ok = (int'(bus.din_chan_in) < N_CHAN) && lock_en_in[bus.din_chan_in];

    pid_chan_store #(
        .N_CHAN (N_CHAN),
        .W_CHAN (W_CHAN),
        .W_DATA (W_DATA),
        .W_COEF (W_COEF),
        .W_INT  (W_INT)
    ) u_store (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .cfg_wr_in       (cfg_wr_in),
        .cfg_chan_in     (cfg_chan_in),
        .cfg_setpoint_in (cfg_setpoint_in),
        .cfg_p_in        (cfg_p_in),
        .cfg_i_in        (cfg_i_in),
        .cfg_d_in        (cfg_d_in),
        .cfg_int_lim_in  (cfg_int_lim_in),
        .commit_en_in    (state_reg == ST_INTEG),
        .commit_chan_in  (chan_reg),
        .commit_int_in   (int_new),
        .commit_eprev_in (e_reg),
        .lock_en_in      (lock_en_in),
        .rd_chan_in      (rd_chan),
        .rd_setpoint_out (rd_sp),
        .rd_p_out        (rd_p),
        .rd_i_out        (rd_i),
        .rd_d_out        (rd_d),
        .rd_int_lim_out  (rd_lim),
        .rd_int_out      (rd_int),
        .rd_eprev_out    (rd_eprev)
    );

    // Integral update with symmetric anti-windup clamp, one guard bit wide.
    always_comb begin
        int_sum = W_IA'(rd_int) + W_IA'(e_reg);
        lim_pos = signed'({2'b00, lim_reg});
        lim_neg = -lim_pos;
        if (int_sum > lim_pos)
            int_new = lim_pos[W_INT-1:0];
        else if (int_sum < lim_neg)
            int_new = lim_neg[W_INT-1:0];
        else
            int_new = int_sum[W_INT-1:0];
        der_new = W_D'(e_reg) - W_D'(rd_eprev);
    end

    always_comb begin
        sum_all = W_S'(prod_p_reg) + W_S'(prod_i_reg) + W_S'(prod_d_reg);
        sat_dir = saturate(64'(sum_all), W_OUT);
        case (sat_dir)
            SAT_HI:  sat_word = {1'b0, {(W_OUT-1){1'b1}}};
            SAT_LO:  sat_word = {1'b1, {(W_OUT-1){1'b0}}};
            default: sat_word = sum_all[W_OUT-1:0];
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg     <= ST_IDLE;
            x_reg         <= '0;
            chan_reg      <= '0;
            sp_reg        <= '0;
            kp_reg        <= '0;
            ki_reg        <= '0;
            kd_reg        <= '0;
            lim_reg       <= '1;
            e_reg         <= '0;
            int_reg       <= '0;
            der_reg       <= '0;
            prod_p_reg    <= '0;
            prod_i_reg    <= '0;
            prod_d_reg    <= '0;
            dout_reg      <= '0;
            dout_chan_reg <= '0;
            dout_dv_reg   <= 1'b0;
            sat_reg       <= 1'b0;
        end else begin
            dout_dv_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Invalid tags and unlocked channels are accepted and discarded.
                    if (bus.din_dv_in && chan_ok) begin
                        x_reg     <= bus.din_in;
                        chan_reg  <= bus.din_chan_in;
                        sp_reg    <= rd_sp;
                        kp_reg    <= rd_p;
                        ki_reg    <= rd_i;
                        kd_reg    <= rd_d;
                        lim_reg   <= rd_lim;
                        state_reg <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    e_reg     <= W_E'(sp_reg) - W_E'(x_reg);
                    state_reg <= ST_INTEG;
                end
                ST_INTEG: begin
                    int_reg   <= int_new;
                    der_reg   <= der_new;
                    state_reg <= ST_MULT;
                end
                ST_MULT: begin
                    prod_p_reg <= W_PP'(kp_reg) * W_PP'(e_reg);
                    prod_i_reg <= W_PI'(ki_reg) * W_PI'(int_reg);
                    prod_d_reg <= W_PD'(kd_reg) * W_PD'(der_reg);
                    state_reg  <= ST_SUM;
                end
                ST_SUM: begin
                    dout_reg      <= sat_word;
                    dout_chan_reg <= chan_reg;
                    sat_reg       <= (sat_dir != SAT_NONE);
                    dout_dv_reg   <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.din_ready_out = (state_reg == ST_IDLE);
    assign bus.dout_out      = dout_reg;
    assign bus.dout_chan_out = dout_chan_reg;
    assign bus.dout_dv_out   = dout_dv_reg;
    assign bus.sat_out       = sat_reg;

endmodule

// File: tb/tb_pid_filter_mc.sv
module tb_pid_filter_mc;
    localparam int W_DATA = 18;
    localparam int W_COEF = 16;
    localparam int W_INT  = 32;
    localparam int W_LIM  = W_INT - 1;
    localparam int W_OUT  = 18;
    localparam int N_CHAN = 6;
    localparam int W_CHAN = 3;
    localparam longint OUT_MAX = 131071;
    localparam longint OUT_MIN = -131072;
    localparam longint LIM_MAX = 64'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N_CHAN-1:0]        lock_en;
    logic [W_CHAN-1:0]        cfg_chan;
    logic signed [W_COEF-1:0] cfg_sp, cfg_p, cfg_i, cfg_d;
    logic [W_LIM-1:0]         cfg_lim;
    logic                     cfg_wr;

    pid_filter_mc_if #(.W_DATA(W_DATA), .W_OUT(W_OUT), .W_CHAN(W_CHAN)) bus ();

    pid_filter_mc #(
        .W_DATA(W_DATA), .W_COEF(W_COEF), .W_INT(W_INT), .W_OUT(W_OUT), .N_CHAN(N_CHAN)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .bus             (bus),
        .lock_en_in      (lock_en),
        .cfg_chan_in     (cfg_chan),
        .cfg_setpoint_in (cfg_sp),
        .cfg_p_in        (cfg_p),
        .cfg_i_in        (cfg_i),
        .cfg_d_in        (cfg_d),
        .cfg_int_lim_in  (cfg_lim),
        .cfg_wr_in       (cfg_wr)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural reference: per-channel config and state as plain integers.
    longint m_sp [N_CHAN];
    longint m_p  [N_CHAN];
    longint m_i  [N_CHAN];
    longint m_d  [N_CHAN];
    longint m_lim[N_CHAN];
    longint m_int[N_CHAN];
    longint m_ep [N_CHAN];
    longint last_out;

    task automatic model_reset();
        for (int c = 0; c < N_CHAN; c++) begin
            m_sp[c] = 0; m_p[c] = 0; m_i[c] = 0; m_d[c] = 0;
            m_lim[c] = LIM_MAX; m_int[c] = 0; m_ep[c] = 0;
        end
        last_out = 0;
    endtask

    task automatic model_step(input int ch, input longint x, output longint u, output bit sat);
        longint e, s, der;
        e = m_sp[ch] - x;
        s = m_int[ch] + e;
        if (s > m_lim[ch]) s = m_lim[ch];
        if (s < -m_lim[ch]) s = -m_lim[ch];
        der = e - m_ep[ch];
        u = m_p[ch] * e + m_i[ch] * s + m_d[ch] * der;
        m_int[ch] = s;
        m_ep[ch] = e;
        sat = 1'b0;
        if (u > OUT_MAX) begin u = OUT_MAX; sat = 1'b1; end
        else if (u < OUT_MIN) begin u = OUT_MIN; sat = 1'b1; end
    endtask

    task automatic cfg_write(input int ch, input longint sp, input longint p, input longint i,
                             input longint d, input longint lim);
        @(negedge clk);
        cfg_chan = W_CHAN'(ch);
        cfg_sp = W_COEF'(sp); cfg_p = W_COEF'(p); cfg_i = W_COEF'(i); cfg_d = W_COEF'(d);
        cfg_lim = W_LIM'(lim);
        cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        if (ch < N_CHAN) begin
            m_sp[ch] = sp; m_p[ch] = p; m_i[ch] = i; m_d[ch] = d; m_lim[ch] = lim;
        end
        $display("cfg ch=%0d sp=%0d p=%0d i=%0d d=%0d lim=%0d", ch, sp, p, i, d, lim);
    endtask

    task automatic set_lock(input logic [N_CHAN-1:0] mask);
        @(negedge clk);
        lock_en = mask;
        for (int c = 0; c < N_CHAN; c++)
            if (!mask[c]) begin m_int[c] = 0; m_ep[c] = 0; end
        $display("lock mask=%b", mask);
    endtask

    // One transfer, then watch 7 edges for output timing, value and ready.
    task automatic do_sample(input string name, input int ch, input longint x,
                             input bit use_req, input longint req, input bit req_sat);
        longint exp_u, got;
        bit exp_sat, exp_out, got_sat, want_rdy, rdy_bad;
        int seen, seen_cyc, got_ch;
        exp_u = 0; exp_sat = 0; got = 0; got_sat = 0; got_ch = 0;
        exp_out = (ch < N_CHAN) && lock_en[ch];
        @(negedge clk);
        checks++;
        if (bus.din_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_idle got %b want 1", name, bus.din_ready_out);
        end
        bus.din_in = W_DATA'(x);
        bus.din_chan_in = W_CHAN'(ch);
        bus.din_dv_in = 1'b1;
        @(posedge clk); #1;
        bus.din_dv_in = 1'b0;
        if (exp_out) begin
            model_step(ch, x, exp_u, exp_sat);
            if (use_req) begin exp_u = req; exp_sat = req_sat; end
        end
        seen = 0; seen_cyc = 0; rdy_bad = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (bus.dout_dv_out === 1'b1) begin
                seen++; seen_cyc = k;
                got = longint'(bus.dout_out); got_ch = int'(bus.dout_chan_out); got_sat = bus.sat_out;
            end
            want_rdy = exp_out ? (k >= 4) : 1'b1;
            if (bus.din_ready_out !== want_rdy) rdy_bad = 1'b1;
        end
        checks++;
        if (rdy_bad) begin
            errors++;
            $display("FAIL %s ready_seq got wrong ready pattern want %s", name,
                     exp_out ? "low 3 cycles" : "always high");
        end
        if (exp_out) begin
            checks++;
            if (seen != 1 || seen_cyc != 4) begin
                errors++;
                $display("FAIL %s dv_timing got count=%0d cycle=%0d want count=1 cycle=4", name, seen, seen_cyc);
            end
            checks++;
            if (got != exp_u) begin
                errors++;
                $display("FAIL %s dout got %0d want %0d", name, got, exp_u);
            end
            checks++;
            if (got_ch != ch || got_sat != exp_sat) begin
                errors++;
                $display("FAIL %s chan_sat got ch=%0d sat=%0b want ch=%0d sat=%0b", name, got_ch, got_sat, ch, exp_sat);
            end
            last_out = exp_u;
        end else begin
            checks++;
            if (seen != 0 || longint'(bus.dout_out) != last_out) begin
                errors++;
                $display("FAIL %s drop got dv_count=%0d dout=%0d want 0 and %0d", name, seen,
                         longint'(bus.dout_out), last_out);
            end
        end
        $display("sample %s ch=%0d x=%0d expect_out=%0b dout=%0d sat=%0b", name, ch, x, exp_out, got, got_sat);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.din_ready_out !== 1'b1 || bus.dout_out !== '0 || bus.dout_chan_out !== '0 ||
            bus.dout_dv_out !== 1'b0 || bus.sat_out !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_state got rdy=%b dout=%0d ch=%0d dv=%b sat=%b want 1 0 0 0 0", name,
                     bus.din_ready_out, bus.dout_out, bus.dout_chan_out, bus.dout_dv_out, bus.sat_out);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_idle_outputs("reset_asserted");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_released");
        model_reset();
    endtask

    task automatic test_basic_pid();
        cfg_write(0, 0, 10, 3, 2, LIM_MAX);
        cfg_write(3, 0, 1, 0, 0, LIM_MAX);
        do_sample("basic_x10", 0, 10, 1, -150, 0);
        do_sample("iso_ch3", 3, 5, 1, -5, 0);
        do_sample("basic_x20", 0, 20, 1, -310, 0);
    endtask

    task automatic test_anti_windup();
        cfg_write(1, 0, 0, 1, 0, 15);
        do_sample("windup_1", 1, -10, 1, 10, 0);
        do_sample("windup_2", 1, -10, 1, 15, 0);
        do_sample("windup_3", 1, -10, 1, 15, 0);
    endtask

    task automatic test_saturation();
        cfg_write(2, 0, 32767, 0, 0, LIM_MAX);
        do_sample("sat_hi", 2, -131072, 1, 131071, 1);
        cfg_write(2, 0, -32767, 0, 0, LIM_MAX);
        do_sample("sat_lo", 2, -131072, 1, -131072, 1);
    endtask

    task automatic test_lock();
        set_lock(6'b111110);
        do_sample("locked_ch0", 0, 10, 0, 0, 0);
        set_lock(6'b111111);
        do_sample("relock_ch0", 0, 10, 1, -150, 0);
        do_sample("bad_chan", N_CHAN, 10, 0, 0, 0);
        cfg_write(7, 1000, 1000, 1000, 1000, 5);
        do_sample("cfg_oor_ch3", 3, 9, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        longint e1, e2, v[2];
        bit s1, s2;
        int cyc[2], chn[2], n;
        @(negedge clk);
        bus.din_in = W_DATA'(7); bus.din_chan_in = 3'd3; bus.din_dv_in = 1'b1;
        @(posedge clk); #1;
        model_step(3, 7, e1, s1);
        bus.din_in = W_DATA'(3); bus.din_chan_in = 3'd1;
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin bus.din_dv_in = 1'b0; model_step(1, 3, e2, s2); end
            if (bus.dout_dv_out === 1'b1) begin
                if (n < 2) begin v[n] = longint'(bus.dout_out); chn[n] = int'(bus.dout_chan_out); cyc[n] = k; end
                n++;
            end
        end
        bus.din_dv_in = 1'b0;
        checks++;
        if (n != 2 || cyc[0] != 4 || cyc[1] != 9) begin
            errors++;
            $display("FAIL b2b_timing got count=%0d cycles=%0d,%0d want 2 at 4,9", n, cyc[0], cyc[1]);
        end
        checks++;
        if (v[0] != e1 || chn[0] != 3 || v[1] != e2 || chn[1] != 1) begin
            errors++;
            $display("FAIL b2b_values got %0d/ch%0d %0d/ch%0d want %0d/ch3 %0d/ch1", v[0], chn[0], v[1], chn[1], e1, e2);
        end
        last_out = e2;
        $display("b2b ch3 x=7 -> %0d, ch1 x=3 -> %0d", v[0], v[1]);
    endtask

    // Config write on the very edge of a transfer on the same channel.
    task automatic test_cfg_collision();
        longint eu, got;
        bit es;
        int seen, cyc;
        @(negedge clk);
        cfg_chan = 3'd3; cfg_sp = 16'sd100; cfg_p = 16'sd2; cfg_i = 16'sd0; cfg_d = 16'sd1;
        cfg_lim = W_LIM'(LIM_MAX); cfg_wr = 1'b1;
        bus.din_in = W_DATA'(-50); bus.din_chan_in = 3'd3; bus.din_dv_in = 1'b1;
        @(posedge clk); #1;
        cfg_wr = 1'b0; bus.din_dv_in = 1'b0;
        model_step(3, -50, eu, es);
        m_sp[3] = 100; m_p[3] = 2; m_i[3] = 0; m_d[3] = 1; m_lim[3] = LIM_MAX;
        seen = 0; cyc = 0; got = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (bus.dout_dv_out === 1'b1) begin seen++; cyc = k; got = longint'(bus.dout_out); end
        end
        checks++;
        if (seen != 1 || cyc != 4 || got != eu) begin
            errors++;
            $display("FAIL cfg_collision got count=%0d cycle=%0d dout=%0d want 1 4 %0d", seen, cyc, got, eu);
        end
        last_out = eu;
        $display("collision ch3 x=-50 -> %0d", got);
        do_sample("after_collision", 3, -50, 0, 0, 0);
    endtask

    task automatic test_random();
        logic signed [W_DATA-1:0] rx;
        logic signed [W_COEF-1:0] rsp, rp, ri, rd;
        int r, ch;
        longint lim;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                rsp = W_COEF'($urandom); rp = W_COEF'($urandom);
                ri = W_COEF'($urandom); rd = W_COEF'($urandom);
                lim = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(0, 2000)) : LIM_MAX;
                cfg_write(int'($urandom_range(0, 7)), rsp, rp, ri, rd, lim);
            end else if (r == 1) begin
                set_lock(N_CHAN'($urandom | $urandom));
            end else begin
                rx = W_DATA'($urandom);
                ch = int'($urandom_range(0, 7));
                do_sample("random", ch, longint'(rx), 0, 0, 0);
            end
        end
        set_lock('1);
    endtask

    task automatic test_reset_midflight();
        int seen;
        @(negedge clk);
        bus.din_in = W_DATA'(10); bus.din_chan_in = 3'd0; bus.din_dv_in = 1'b1;
        @(posedge clk); #1;
        bus.din_dv_in = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.dout_dv_out !== 1'b0) seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_midflight_dv got %0d pulses want 0", seen);
        end
        @(negedge clk);
        check_idle_outputs("after_midflight_reset");
        $display("reset mid-flight done");
        cfg_write(0, 0, 10, 3, 2, LIM_MAX);
        do_sample("post_reset_x10", 0, 10, 1, -150, 0);
    endtask

    initial begin
        rst = 1'b1;
        lock_en = '1;
        cfg_wr = 1'b0; cfg_chan = '0; cfg_sp = '0; cfg_p = '0; cfg_i = '0; cfg_d = '0; cfg_lim = '0;
        bus.din_in = '0; bus.din_chan_in = '0; bus.din_dv_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        test_reset();
        test_basic_pid();
        test_anti_windup();
        test_saturation();
        test_lock();
        test_back_to_back();
        test_cfg_collision();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
